// File: rtl/piso_out_ctrl.sv
// Sequencing controller for the NPU output PISO: captures one result vector,
// drives the PISO load/shift controls and presents each word downstream.
module piso_out_ctrl #(
   parameter int WIDTH    = 8,
   parameter int NUM_TAPS = 4,
   parameter int IDX_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
   input  logic                      CLKEXT,
   input  logic                      RST,
   input  logic                      SOFT_CLR,
   input  logic                      IN_VALID,
   output logic                      IN_READY,
   input  logic [WIDTH*NUM_TAPS-1:0] IN_DATA,
   output logic [WIDTH*NUM_TAPS-1:0] PISO_DATA,
   output logic                      CLR_PISO_OUT,
   output logic                      SHIFT_OUT,
   output logic                      EN_PISO_OUT,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic [IDX_W-1:0]          OUT_IDX,
   output logic                      OUT_LAST,
   output logic                      FRAME_DONE,
   output logic [1:0]                STATE_DBG
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready, and a raised OUT_VALID is held
   // until its word is taken (or SOFT_CLR/RST abort the vector).
   typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, STREAM} state_t;

   state_t state;
   logic   in_hs;
   logic   out_hs;

   assign OUT_VALID   = (state == STREAM);
   assign OUT_LAST    = OUT_VALID && (OUT_IDX == '0);
   assign EN_PISO_OUT = OUT_VALID && OUT_READY && !OUT_LAST;
   assign in_hs       = IN_VALID && IN_READY;
   assign out_hs      = OUT_VALID && OUT_READY;
   assign STATE_DBG   = state;

   // A new vector may also enter while the final word of the previous one leaves.
   always_comb begin
      IN_READY = 1'b0;
      case (state)
         IDLE:    IN_READY = !CLR_PISO_OUT;
         STREAM:  IN_READY = OUT_READY && OUT_LAST && !CLR_PISO_OUT;
         default: IN_READY = 1'b0;
      endcase
   end

   always_ff @(posedge CLKEXT) begin
      if (RST) begin
         state        <= IDLE;
         PISO_DATA    <= '0;
         OUT_IDX      <= '0;
         CLR_PISO_OUT <= 1'b1;
         FRAME_DONE   <= 1'b0;
         SHIFT_OUT    <= 1'b1;
      end else begin
         CLR_PISO_OUT <= SOFT_CLR;
         FRAME_DONE   <= 1'b0;
         if (SOFT_CLR) begin
            // Abort wins over any same-cycle capture; PISO_DATA is left as is.
            state     <= IDLE;
            OUT_IDX   <= '0;
            SHIFT_OUT <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (in_hs) begin
                     PISO_DATA <= IN_DATA;
                     state     <= LOAD_A;
                     SHIFT_OUT <= 1'b0;
                  end
               end
               LOAD_A: begin
                  // PISO staging register takes the new vector at this edge.
                  state <= LOAD_B;
               end
               LOAD_B: begin
                  OUT_IDX   <= IDX_W'(NUM_TAPS - 1);
                  state     <= STREAM;
                  SHIFT_OUT <= 1'b1;
               end
               STREAM: begin
                  if (out_hs) begin
                     if (!OUT_LAST) begin
                        OUT_IDX <= OUT_IDX - IDX_W'(1);
                     end else begin
                        FRAME_DONE <= 1'b1;
                        if (in_hs) begin
                           PISO_DATA <= IN_DATA;
                           state     <= LOAD_A;
                           SHIFT_OUT <= 1'b0;
                        end else begin
                           state <= IDLE;
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_piso_out_ctrl.sv
// Bench for piso_out_ctrl: a transaction-level model of the vector/word flow
// plus a behavioural PISO, compared every cycle on the falling edge.
module tb_piso_out_ctrl;
   localparam int W  = 8;
   localparam int N  = 4;
   localparam int IW = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst = 1'b1, soft_clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [W*N-1:0] in_data = '0;
   logic           in_ready, clr_piso, shift_out, en_piso, out_valid, out_last, frame_done;
   logic [W*N-1:0] piso_data;
   logic [IW-1:0]  out_idx;
   logic [1:0]     state_dbg;

   logic           rst_1 = 1'b1, soft_clr_1 = 1'b0, in_valid_1 = 1'b0, out_ready_1 = 1'b0;
   logic [W-1:0]   in_data_1 = '0;
   logic           in_ready_1, clr_piso_1, shift_out_1, en_piso_1, out_valid_1, out_last_1;
   logic           frame_done_1;
   logic [W-1:0]   piso_data_1;
   logic [0:0]     out_idx_1;
   logic [1:0]     state_dbg_1;

   piso_out_ctrl #(.WIDTH(W), .NUM_TAPS(N)) dut (
      .CLKEXT(clk), .RST(rst), .SOFT_CLR(soft_clr), .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_DATA(in_data), .PISO_DATA(piso_data), .CLR_PISO_OUT(clr_piso), .SHIFT_OUT(shift_out),
      .EN_PISO_OUT(en_piso), .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_IDX(out_idx),
      .OUT_LAST(out_last), .FRAME_DONE(frame_done), .STATE_DBG(state_dbg)
   );

   piso_out_ctrl #(.WIDTH(W), .NUM_TAPS(1)) dut_1 (
      .CLKEXT(clk), .RST(rst_1), .SOFT_CLR(soft_clr_1), .IN_VALID(in_valid_1),
      .IN_READY(in_ready_1), .IN_DATA(in_data_1), .PISO_DATA(piso_data_1),
      .CLR_PISO_OUT(clr_piso_1), .SHIFT_OUT(shift_out_1), .EN_PISO_OUT(en_piso_1),
      .OUT_VALID(out_valid_1), .OUT_READY(out_ready_1), .OUT_IDX(out_idx_1),
      .OUT_LAST(out_last_1), .FRAME_DONE(frame_done_1), .STATE_DBG(state_dbg_1)
   );

   // Behavioural PISO: one staging register, DATA_OUT is the top tap.
   logic [W-1:0] stage_r [N];
   logic [W-1:0] taps    [N];
   always @(posedge clk) begin
      if (clr_piso) begin
         for (int i = 0; i < N; i++) begin
            stage_r[i] <= '0;
            taps[i]    <= '0;
         end
      end else if (!shift_out) begin
         for (int i = 0; i < N; i++) begin
            stage_r[i] <= piso_data[W*i +: W];
            taps[i]    <= stage_r[i];
         end
      end else if (en_piso) begin
         for (int i = 1; i < N; i++) taps[i] <= taps[i-1];
         taps[0] <= '0;
      end
   end

   // ---------------- scoreboard / reference model ----------------
   logic [W-1:0]   exp_q[$];     // words of the current vector still to leave, in order
   int             load_wait;    // load cycles left before the first word is out
   logic           m_clr, m_fd, m_accept;
   logic [W*N-1:0] m_piso;
   logic           e_in_ready, e_out_valid;
   int             n_checks = 0, n_pass = 0;
   int             cyc = 0, last_acc = 0, last_fd = 0, n_shift = 0, n_fd = 0, n_clr = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic predict();
      e_out_valid = (load_wait == 0) && (exp_q.size() > 0);
      e_in_ready  = !m_clr && ((exp_q.size() == 0) ||
                               (e_out_valid && out_ready && exp_q.size() == 1));
   endtask

   task automatic check_outputs();
      predict();
      chk("in_ready",     in_ready,   e_in_ready);
      chk("out_valid",    out_valid,  e_out_valid);
      chk("shift_out",    shift_out,  load_wait == 0);
      chk("en_piso_out",  en_piso,    e_out_valid && out_ready && exp_q.size() > 1);
      chk("clr_piso_out", clr_piso,   m_clr);
      chk("frame_done",   frame_done, m_fd);
      chk("out_idx",      out_idx,    e_out_valid ? exp_q.size() - 1 : 0);
      chk("piso_data",    piso_data,  m_piso);
      if (e_out_valid) begin
         chk("out_last", out_last,   exp_q.size() == 1);
         chk("data_out", taps[N-1], exp_q[0]);
      end
   endtask

   task automatic model_step();
      m_accept = 1'b0;
      if (rst) begin
         exp_q.delete();
         load_wait = 0;
         m_clr     = 1'b1;
         m_fd      = 1'b0;
         m_piso    = '0;
      end else begin
         m_clr = soft_clr;
         m_fd  = 1'b0;
         if (soft_clr) begin
            exp_q.delete();
            load_wait = 0;
         end else begin
            if (load_wait > 0) load_wait--;
            else if (e_out_valid && out_ready) begin
               if (exp_q.size() == 1) m_fd = 1'b1;
               exp_q.delete(0);
            end
            if (in_valid && e_in_ready) begin
               m_accept = 1'b1;
               m_piso   = in_data;
               for (int i = N - 1; i >= 0; i--) exp_q.push_back(in_data[W*i +: W]);
               load_wait = 2;
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(negedge clk);
      check_outputs();
      if (en_piso)    n_shift++;
      if (frame_done) begin n_fd++; last_fd = cyc; end
      if (clr_piso)   n_clr++;
      @(posedge clk);
      model_step();
      if (m_accept) last_acc = cyc;
      cyc++;
      #1;
   endtask

   task automatic send_vec(input logic [W*N-1:0] vec);
      logic ok;
      ok       = 1'b0;
      in_data  = vec;
      in_valid = 1'b1;
      for (int k = 0; k < 20 && !ok; k++) begin
         cycle();
         if (m_accept) ok = 1'b1;
      end
      in_valid = 1'b0;
      chk("accept_timeout", ok, 1'b1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int pat [7];
      int acc0, n_acc;
      pat = '{1, 0, 0, 1, 1, 0, 1};

      @(posedge clk);
      model_step();
      #1;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      cycle();

      // basic vector, downstream always ready
      out_ready = 1'b1;
      send_vec(32'h4433_2211);
      repeat (8) cycle();
      chk("frame_done_latency", last_fd - last_acc, N + 3);

      // downstream stalls: exactly NUM_TAPS-1 shift pulses
      send_vec(32'h4433_2211);
      n_shift = 0;
      repeat (2) cycle();
      for (int k = 0; k < 7; k++) begin
         out_ready = pat[k][0];
         cycle();
      end
      out_ready = 1'b1;
      repeat (3) cycle();
      chk("shift_pulses", n_shift, 3);

      // back-to-back vectors with IN_VALID held
      n_acc = 0;
      acc0  = 0;
      in_valid = 1'b1;
      in_data  = {$urandom};
      for (int k = 0; k < 30 && n_acc < 2; k++) begin
         cycle();
         if (m_accept) begin
            n_acc++;
            if (n_acc == 1) acc0 = last_acc;
            in_data = {$urandom};
         end
      end
      in_valid = 1'b0;
      chk("b2b_accepts", n_acc, 2);
      chk("b2b_period", last_acc - acc0, N + 2);
      repeat (8) cycle();

      // SOFT_CLR on the second streamed word, then a collision with an accept
      send_vec(32'hDEAD_BEEF);
      n_fd = 0;
      repeat (3) cycle();
      soft_clr = 1'b1;
      cycle();
      soft_clr = 1'b0;
      cycle();
      in_valid = 1'b1;
      soft_clr = 1'b1;
      cycle();
      in_valid = 1'b0;
      soft_clr = 1'b0;
      repeat (4) cycle();
      chk("no_frame_done_on_abort", n_fd, 0);

      // RST during LOAD_B for three sampling edges: CLR high once per edge
      send_vec(32'hA1B2_C3D4);
      cycle();
      rst   = 1'b1;
      n_clr = 0;
      repeat (3) cycle();
      rst = 1'b0;
      repeat (3) cycle();
      chk("clr_after_rst", n_clr, 3);
      send_vec(32'h0F1E_2D3C);
      repeat (8) cycle();

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom};
         soft_clr  = ($urandom_range(0, 39) == 0);
         cycle();
      end
      in_valid  = 1'b0;
      soft_clr  = 1'b0;
      out_ready = 1'b1;
      repeat (10) cycle();

      // single-tap instance
      rst_1 = 1'b0;
      @(negedge clk);
      chk("t1_ready_after_rst", in_ready_1, 1'b0);
      chk("t1_clr_after_rst",   clr_piso_1, 1'b1);
      @(posedge clk); #1;
      in_valid_1 = 1'b1;
      in_data_1  = 8'hA5;
      @(negedge clk);
      chk("t1_ready", in_ready_1, 1'b1);
      @(posedge clk); #1;
      in_valid_1  = 1'b0;
      out_ready_1 = 1'b1;
      @(negedge clk);
      chk("t1_load_a_shift", shift_out_1, 1'b0);
      chk("t1_load_a_valid", out_valid_1, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t1_load_b_shift", shift_out_1, 1'b0);
      chk("t1_load_b_en",    en_piso_1,   1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t1_stream_valid", out_valid_1,  1'b1);
      chk("t1_stream_last",  out_last_1,   1'b1);
      chk("t1_stream_en",    en_piso_1,    1'b0);
      chk("t1_stream_idx",   out_idx_1,    1'b0);
      chk("t1_stream_data",  piso_data_1,  8'hA5);
      chk("t1_stream_fd",    frame_done_1, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t1_frame_done",   frame_done_1, 1'b1);
      chk("t1_after_valid",  out_valid_1,  1'b0);
      chk("t1_after_en",     en_piso_1,    1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t1_frame_done_pulse", frame_done_1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
